// File: rtl/pc_fetch_pkg.sv
// ============================================================================
// Module : pc_fetch_pkg
// Brief  : Shared types and defaults for the PC fetch sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_t;

  localparam int unsigned DEFAULT_INSTR_BYTES = 4;
  localparam logic [63:0] DEFAULT_RESET_PC    = 64'h0;

endpackage : pc_fetch_pkg

`default_nettype wire

// File: rtl/fetch_rsp_buffer.sv
// ============================================================================
// Module : fetch_rsp_buffer
// Brief  : One-entry pc+instr holding register for a stalled fetch response.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_rsp_buffer #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned ILEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [ILEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [ILEN-1:0] instr_o
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] instr_q;

  // Clear wins over load so a discard can never leave a stale entry behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule : fetch_rsp_buffer

`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
// ============================================================================
// Module : pc_fetch_sequencer
// Brief  : Drives program-counter updates and a single-outstanding imem fetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch_sequencer
  import pc_fetch_pkg::*;
#(
  parameter int unsigned     XLEN        = 64,
  parameter int unsigned     ILEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEFAULT_RESET_PC),
  parameter int unsigned     INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc_cur,
  output logic [XLEN-1:0] pc_next,
  output logic            pc_en,
  input  logic            stall_i,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [ILEN-1:0] if_instr
);

  localparam logic [XLEN-1:0] c_pc_incr = XLEN'(INSTR_BYTES);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] req_pc_q;
  logic            w_accept;
  logic            w_buf_load;
  logic            w_buf_clear;
  logic            w_buf_valid;
  logic [XLEN-1:0] w_buf_pc;
  logic [ILEN-1:0] w_buf_instr;

  assign imem_req_addr = pc_cur;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_accept) req_pc_q <= pc_cur;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_en          = 1'b0;
    pc_next        = pc_cur;
    imem_req_valid = 1'b0;
    if_valid       = 1'b0;
    if_pc          = '0;
    if_instr       = '0;
    w_accept       = 1'b0;
    w_buf_load     = 1'b0;
    w_buf_clear    = 1'b0;

    case (state_q)
      IDLE: state_d = ISSUE;

      ISSUE: begin
        if (redirect_valid) begin
          pc_en   = 1'b1;
          pc_next = redirect_pc;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) begin
            pc_en    = 1'b1;
            pc_next  = pc_cur + c_pc_incr;
            w_accept = 1'b1;
            state_d  = WAIT;
          end
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          pc_en   = 1'b1;
          pc_next = redirect_pc;
          state_d = imem_rsp_valid ? ISSUE : DRAIN;
        end else if (imem_rsp_valid) begin
          // The response is presented even while stalled; the buffer keeps it alive.
          if_valid = 1'b1;
          if_pc    = req_pc_q;
          if_instr = imem_rsp_data;
          if (stall_i) begin
            w_buf_load = 1'b1;
            state_d    = HOLD;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_en       = 1'b1;
          pc_next     = redirect_pc;
          w_buf_clear = 1'b1;
          state_d     = ISSUE;
        end else begin
          if_valid = w_buf_valid;
          if_pc    = w_buf_pc;
          if_instr = w_buf_instr;
          if (!stall_i) begin
            w_buf_clear = 1'b1;
            state_d     = ISSUE;
          end
        end
      end

      DRAIN: begin
        if (redirect_valid) begin
          pc_en   = 1'b1;
          pc_next = redirect_pc;
        end
        // The stale response still has to be absorbed before a new request.
        if (imem_rsp_valid) state_d = ISSUE;
      end

      default: state_d = IDLE;
    endcase

    if (!reset_n) pc_next = RESET_PC;
  end

  fetch_rsp_buffer #(
    .XLEN (XLEN),
    .ILEN (ILEN)
  ) u_rsp_buffer (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (w_buf_load),
    .clear_i (w_buf_clear),
    .pc_i    (req_pc_q),
    .instr_i (imem_rsp_data),
    .valid_o (w_buf_valid),
    .pc_o    (w_buf_pc),
    .instr_o (w_buf_instr)
  );

endmodule : pc_fetch_sequencer

`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
// ============================================================================
// Module : tb_pc_fetch_sequencer
// Brief  : Directed cycle-table bench for pc_fetch_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_sequencer;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int NV = 34;

  typedef struct {
    logic            rdy;
    logic            rsp_v;
    logic [ILEN-1:0] rsp_d;
    logic            stall;
    logic            redir;
    logic [XLEN-1:0] rpc;
    logic            rv;
    logic [XLEN-1:0] addr;
    logic            en;
    logic [XLEN-1:0] nxt;
    logic            iv;
    logic [XLEN-1:0] ipc;
    logic [ILEN-1:0] instr;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [XLEN-1:0] pc_cur;
  logic [XLEN-1:0] pc_next;
  logic            pc_en;
  logic            stall_i;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_instr;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl [NV];
  vec_t v;

  always #5 clk = ~clk;

  // Program counter register: loads the reset vector while held in reset.
  always_ff @(posedge clk) begin
    if (!reset_n || pc_en) pc_cur <= pc_next;
  end

  pc_fetch_sequencer #(
    .XLEN        (XLEN),
    .ILEN        (ILEN),
    .RESET_PC    (64'h0),
    .INSTR_BYTES (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc_cur         (pc_cur),
    .pc_next        (pc_next),
    .pc_en          (pc_en),
    .stall_i        (stall_i),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  function automatic vec_t mk(input logic rdy, input logic rsp_v, input logic [ILEN-1:0] d,
                              input logic st, input logic rd, input logic [XLEN-1:0] rpc,
                              input logic rv, input logic [XLEN-1:0] a, input logic en,
                              input logic [XLEN-1:0] n, input logic iv,
                              input logic [XLEN-1:0] ipc, input logic [ILEN-1:0] ins);
    vec_t r;
    r.rdy = rdy; r.rsp_v = rsp_v; r.rsp_d = d; r.stall = st; r.redir = rd; r.rpc = rpc;
    r.rv = rv; r.addr = a; r.en = en; r.nxt = n; r.iv = iv; r.ipc = ipc; r.instr = ins;
    return r;
  endfunction

  task automatic drive(input vec_t x);
    imem_req_ready = x.rdy;
    imem_rsp_valid = x.rsp_v;
    imem_rsp_data  = x.rsp_d;
    stall_i        = x.stall;
    redirect_valid = x.redir;
    redirect_pc    = x.rpc;
  endtask

  // strict=1 also checks if_pc/if_instr when if_valid is low (reset values).
  task automatic compare(input string tag, input vec_t x, input bit strict);
    bit bad;
    bad = (imem_req_valid !== x.rv) || (pc_en !== x.en) || (pc_next !== x.nxt) ||
          (if_valid !== x.iv) ||
          (x.rv && (imem_req_addr !== x.addr)) ||
          ((x.iv || strict) && ((if_pc !== x.ipc) || (if_instr !== x.instr)));
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got rv=%0b addr=%0h en=%0b nxt=%0h iv=%0b ipc=%0h ins=%0h; expected rv=%0b addr=%0h en=%0b nxt=%0h iv=%0b ipc=%0h ins=%0h",
               tag, imem_req_valid, imem_req_addr, pc_en, pc_next, if_valid, if_pc, if_instr,
               x.rv, x.addr, x.en, x.nxt, x.iv, x.ipc, x.instr);
    end
  endtask

  // Called at a negedge: drive, settle, check, then advance to the next negedge.
  task automatic step(input string tag, input vec_t x, input bit strict);
    drive(x);
    #1;
    compare(tag, x, strict);
    @(negedge clk);
  endtask

  initial begin
    //               rdy rsp d          st rd rpc            rv addr          en nxt            iv ipc           ins
    tbl[0]  = mk(1, 0, 32'h0,       0, 0, 64'h0,      0, 64'h0,     0, 64'h0,     0, 64'h0,     32'h0);
    tbl[1]  = mk(1, 0, 32'h0,       0, 0, 64'h0,      1, 64'h0,     1, 64'h4,     0, 64'h0,     32'h0);
    tbl[2]  = mk(0, 1, 32'hA0,      0, 0, 64'h0,      0, 64'h0,     0, 64'h4,     1, 64'h0,     32'hA0);
    tbl[3]  = mk(1, 0, 32'h0,       0, 0, 64'h0,      1, 64'h4,     1, 64'h8,     0, 64'h0,     32'h0);
    tbl[4]  = mk(0, 1, 32'hA4,      0, 0, 64'h0,      0, 64'h0,     0, 64'h8,     1, 64'h4,     32'hA4);
    tbl[5]  = mk(0, 0, 32'h0,       0, 0, 64'h0,      1, 64'h8,     0, 64'h8,     0, 64'h0,     32'h0);
    tbl[6]  = tbl[5];
    tbl[7]  = tbl[5];
    tbl[8]  = mk(1, 0, 32'h0,       0, 0, 64'h0,      1, 64'h8,     1, 64'hC,     0, 64'h0,     32'h0);
    tbl[9]  = mk(0, 1, 32'h13,      1, 0, 64'h0,      0, 64'h0,     0, 64'hC,     1, 64'h8,     32'h13);
    tbl[10] = mk(0, 0, 32'h0,       1, 0, 64'h0,      0, 64'h0,     0, 64'hC,     1, 64'h8,     32'h13);
    tbl[11] = tbl[10];
    tbl[12] = tbl[10];
    tbl[13] = mk(0, 0, 32'h0,       0, 0, 64'h0,      0, 64'h0,     0, 64'hC,     1, 64'h8,     32'h13);
    tbl[14] = mk(1, 0, 32'h0,       0, 0, 64'h0,      1, 64'hC,     1, 64'h10,    0, 64'h0,     32'h0);
    tbl[15] = mk(0, 0, 32'h0,       0, 1, 64'h100,    0, 64'h0,     1, 64'h100,   0, 64'h0,     32'h0);
    tbl[16] = mk(1, 0, 32'h0,       0, 0, 64'h0,      0, 64'h0,     0, 64'h100,   0, 64'h0,     32'h0);
    tbl[17] = mk(1, 1, 32'hDEAD,    0, 0, 64'h0,      0, 64'h0,     0, 64'h100,   0, 64'h0,     32'h0);
    tbl[18] = mk(1, 0, 32'h0,       0, 0, 64'h0,      1, 64'h100,   1, 64'h104,   0, 64'h0,     32'h0);
    tbl[19] = mk(0, 1, 32'h55,      0, 1, 64'h200,    0, 64'h0,     1, 64'h200,   0, 64'h0,     32'h0);
    tbl[20] = mk(1, 0, 32'h0,       0, 0, 64'h0,      1, 64'h200,   1, 64'h204,   0, 64'h0,     32'h0);
    tbl[21] = mk(0, 1, 32'h66,      1, 0, 64'h0,      0, 64'h0,     0, 64'h204,   1, 64'h200,   32'h66);
    tbl[22] = mk(0, 0, 32'h0,       1, 1, 64'h300,    0, 64'h0,     1, 64'h300,   0, 64'h0,     32'h0);
    tbl[23] = mk(1, 0, 32'h0,       0, 1, 64'h400,    0, 64'h0,     1, 64'h400,   0, 64'h0,     32'h0);
    tbl[24] = mk(1, 0, 32'h0,       0, 0, 64'h0,      1, 64'h400,   1, 64'h404,   0, 64'h0,     32'h0);
    tbl[25] = mk(0, 0, 32'h0,       0, 1, 64'h500,    0, 64'h0,     1, 64'h500,   0, 64'h0,     32'h0);
    tbl[26] = mk(0, 0, 32'h0,       0, 1, 64'h600,    0, 64'h0,     1, 64'h600,   0, 64'h0,     32'h0);
    tbl[27] = mk(0, 1, 32'hBEEF,    0, 0, 64'h0,      0, 64'h0,     0, 64'h600,   0, 64'h0,     32'h0);
    tbl[28] = mk(1, 0, 32'h0,       0, 0, 64'h0,      1, 64'h600,   1, 64'h604,   0, 64'h0,     32'h0);
    tbl[29] = mk(0, 1, 32'h77,      0, 0, 64'h0,      0, 64'h0,     0, 64'h604,   1, 64'h600,   32'h77);
    tbl[30] = mk(1, 0, 32'h0,       0, 1, 64'hFFFF_FFFF_FFFF_FFFC,
                                                      0, 64'h0,     1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 32'h0);
    tbl[31] = mk(1, 0, 32'h0,       0, 0, 64'h0,      1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h0, 0, 64'h0, 32'h0);
    tbl[32] = mk(0, 1, 32'h88,      0, 0, 64'h0,      0, 64'h0,     0, 64'h0,     1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h88);
    tbl[33] = mk(1, 0, 32'h0,       0, 0, 64'h0,      1, 64'h0,     1, 64'h4,     0, 64'h0,     32'h0);

    // Reset state, before and after the PC register has loaded the reset vector.
    reset_n = 1'b0;
    v = mk(0, 0, 32'h0, 0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 32'h0);
    drive(v);
    #1;
    compare("reset_initial", v, 1'b1);
    repeat (3) @(negedge clk);
    compare("reset_held", v, 1'b1);

    reset_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      step($sformatf("vec%0d", i), tbl[i], 1'b0);
    end

    // Asynchronous reset while a response is outstanding (state WAIT, pc_cur=4).
    v = mk(1, 1, 32'hCAFE, 1, 1, 64'h900, 0, 64'h0, 0, 64'h0, 0, 64'h0, 32'h0);
    drive(v);
    #2;
    reset_n = 1'b0;
    #1;
    compare("async_reset_wait", v, 1'b1);
    @(negedge clk);
    compare("reset_after_edge", v, 1'b1);
    v = mk(0, 0, 32'h0, 0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 32'h0);
    drive(v);
    @(negedge clk);
    reset_n = 1'b1;
    step("post_reset_idle", mk(1, 0, 32'h0, 0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 0, 64'h0, 32'h0), 1'b0);
    step("post_reset_issue", mk(1, 0, 32'h0, 0, 0, 64'h0, 1, 64'h0, 1, 64'h4, 0, 64'h0, 32'h0), 1'b0);
    step("post_reset_rsp", mk(0, 1, 32'h1234, 0, 0, 64'h0, 0, 64'h0, 0, 64'h4, 1, 64'h0, 32'h1234), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pc_fetch_sequencer

`default_nettype wire
